prbs8_checker: RTL

// - Receive-side checker for the 8-bit PRBS stream x^8+x^6+x^5+x^4+1 (MSB-first shift-left LFSR, serial out = MSB).
// - Self-synchronises to an incoming serial bitstream, declares lock, then counts bit errors for link/BER test.
// - Sits at the far end of a serial link or loopback, opposite the PRBS generator. Drives status LEDs/display counters.

---
 rtl/prbs8_checker.sv | 138 +++++++++++++
 1 files changed

// File: rtl/prbs8_checker.sv
// Self-synchronising receive checker for PRBS8 (x^8+x^6+x^5+x^4+1), with lock detection and error counting.
// Optional macro PRBS8_CHK_BITCNT_EN adds a 32-bit count of bits sampled while locked (BER denominator).
module prbs8_checker #(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_THR = 8,
    parameter int LOSS_WIN = 64,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             ar,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
`ifdef PRBS8_CHK_BITCNT_EN
   ,output logic [31:0]      bit_cnt
`endif
);

    localparam int WC_W = $clog2(LOSS_WIN);
    localparam int WE_W = $clog2(LOSS_WIN + 1);
    localparam logic [8:0]      LOCK_TGT = 9'(LOCK_CNT);
    localparam logic [WE_W-1:0] THR      = WE_W'(LOSS_THR);
    localparam logic [WC_W-1:0] WIN_LAST = WC_W'(LOSS_WIN - 1);

    typedef enum logic {ST_SEEK, ST_LOCKED} state_t;

    state_t           state_q;
    logic [7:0]       hist_q;
    logic [3:0]       fill_q;
    logic [7:0]       match_q;
    logic [WC_W-1:0]  win_cnt_q;
    logic [WE_W-1:0]  win_err_q;
    logic             locked_q;
    logic             err_pulse_q;
    logic [ERR_W-1:0] err_cnt_q;

    logic             exp_bit;
    logic             mis;
    logic [8:0]       match_d;
    logic [WE_W-1:0]  win_err_d;
    logic [ERR_W-1:0] err_cnt_d;

    assign exp_bit   = hist_q[7] ^ hist_q[5] ^ hist_q[4] ^ hist_q[3];
    assign mis       = din ^ exp_bit;
    assign match_d   = {1'b0, match_q} + 9'd1;
    assign win_err_d = win_err_q + {{(WE_W-1){1'b0}}, mis};
    assign err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;

    // In LOCKED the history is fed from its own prediction (flywheel), so a bad
    // received bit costs exactly one error and never corrupts later predictions.
    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            state_q     <= ST_SEEK;
            hist_q      <= 8'h00;
            fill_q      <= '0;
            match_q     <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            if (din_valid) begin
                case (state_q)
                    ST_SEEK: begin
                        hist_q <= {hist_q[6:0], din};
                        if (fill_q != 4'd8) begin
                            fill_q <= fill_q + 4'd1;
                        end else if (!mis && hist_q != 8'h00) begin
                            if (match_d == LOCK_TGT) begin
                                state_q   <= ST_LOCKED;
                                locked_q  <= 1'b1;
                                match_q   <= '0;
                                win_cnt_q <= '0;
                                win_err_q <= '0;
                            end else begin
                                match_q <= match_d[7:0];
                            end
                        end else begin
                            match_q <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        hist_q      <= {hist_q[6:0], exp_bit};
                        err_pulse_q <= mis;
                        if (mis) begin
                            err_cnt_q <= err_cnt_d;
                        end
                        // Threshold test precedes the wrap so an error on the wrap bit closes its own window.
                        if (win_err_d == THR) begin
                            state_q   <= ST_SEEK;
                            locked_q  <= 1'b0;
                            fill_q    <= '0;
                            match_q   <= '0;
                            win_cnt_q <= '0;
                            win_err_q <= '0;
                        end else if (win_cnt_q == WIN_LAST) begin
                            win_cnt_q <= '0;
                            win_err_q <= '0;
                        end else begin
                            win_cnt_q <= win_cnt_q + 1'b1;
                            win_err_q <= win_err_d;
                        end
                    end
                    default: state_q <= ST_SEEK;
                endcase
            end
            if (clr_cnt) begin
                err_cnt_q <= '0;
            end
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

`ifdef PRBS8_CHK_BITCNT_EN
    logic [31:0] bit_cnt_q;

    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            bit_cnt_q <= '0;
        end else if (clr_cnt) begin
            bit_cnt_q <= '0;
        end else if (din_valid && state_q == ST_LOCKED && bit_cnt_q != 32'hFFFF_FFFF) begin
            bit_cnt_q <= bit_cnt_q + 32'd1;
        end
    end

    assign bit_cnt = bit_cnt_q;
`endif

endmodule
